// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch / decode slice of the core.
//   fetch_state_t : fetch sequencer states
//   imm_type_t    : immediate formats understood by imm_generator
//   NOP_INSTR     : instruction presented before the first fetch completes
//   DEFAULT_RESET_PC : boot address used when no override is given
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD,
        TRAP
    } fetch_state_t;

    typedef enum logic [1:0] {
        IMM_J = 2'b00,
        IMM_I = 2'b01,
        IMM_S = 2'b10,
        IMM_B = 2'b11
    } imm_type_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage.
//   pc              : address of the instruction being retired
//   immediate_value : sign-extended immediate from imm_generator
//   rs1_value       : register-file rs1 read data
//   branch_taken    : conditional branch resolved taken
//   jump            : JAL
//   jalr            : JALR (highest priority)
//   next_pc         : address of the following instruction
//   misaligned      : next_pc is not 4-byte aligned
// All arithmetic wraps modulo 2^XLEN.
module next_pc_calc #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] immediate_value,
    input  logic [XLEN-1:0] rs1_value,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic            jalr,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] jalr_sum;

    assign jalr_sum = rs1_value + immediate_value;

    always_comb begin
        next_pc = pc + XLEN'(4);
        if (jalr) begin
            // JALR drops bit 0 before alignment is judged; bit 1 still traps.
            next_pc = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (jump || branch_taken) begin
            next_pc = pc + immediate_value;
        end
        misaligned = (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with a req/ready memory handshake.
//   clk, rst         : clock, asynchronous active-high reset
//   imem_req/addr    : fetch request and byte address (addr == pc)
//   imem_ready/rdata : memory response, sampled only while requesting
//   instruction      : registered instruction word for decode
//   instr_valid      : instruction/pc valid, waiting for instr_accept
//   instr_accept     : core retired the presented instruction
//   pc, pc_plus4     : current instruction address and its link value
//   branch_taken, jump, jalr, immediate_value, rs1_value :
//                      next-PC controls, sampled on an accepted instruction
//   misaligned_err   : sticky trap flag, cleared only by reset
//   fetch_count      : number of accepted instructions (wraps)
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instruction,
    output logic            instr_valid,
    input  logic            instr_accept,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic            jalr,
    input  logic [XLEN-1:0] immediate_value,
    input  logic [XLEN-1:0] rs1_value,
    output logic            misaligned_err,
    output logic [XLEN-1:0] fetch_count
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] count_q;
    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;
    logic            capture;
    logic            accept;

    next_pc_calc #(
        .XLEN (XLEN)
    ) u_next_pc_calc (
        .pc              (pc_q),
        .immediate_value (immediate_value),
        .rs1_value       (rs1_value),
        .branch_taken    (branch_taken),
        .jump            (jump),
        .jalr            (jalr),
        .next_pc         (next_pc),
        .misaligned      (next_misaligned)
    );

    assign capture = (state_q == FETCH) && imem_ready;
    assign accept  = (state_q == HOLD) && instr_accept;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (imem_ready) state_d = HOLD;
            HOLD:    if (instr_accept) state_d = next_misaligned ? TRAP : FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = BOOT;
        endcase
    end

    // Handshake outputs decode the state register directly, so reset
    // removes them without waiting for a clock edge.
    always_comb begin
        imem_req       = (state_q == FETCH);
        instr_valid    = (state_q == HOLD);
        misaligned_err = (state_q == TRAP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                instr_q <= imem_rdata;
            end
            if (accept) begin
                pc_q    <= next_pc;
                count_q <= count_q + XLEN'(1);
            end
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + XLEN'(4);
    assign instruction = instr_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by
// randomized traffic, all compared each cycle against a transaction-level
// model of the fetch stage.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_accept = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic        jalr = 1'b0;
    logic [31:0] immediate_value = '0;
    logic [31:0] rs1_value = '0;
    logic        misaligned_err;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RPC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instruction     (instruction),
        .instr_valid     (instr_valid),
        .instr_accept    (instr_accept),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .branch_taken    (branch_taken),
        .jump            (jump),
        .jalr            (jalr),
        .immediate_value (immediate_value),
        .rs1_value       (rs1_value),
        .misaligned_err  (misaligned_err),
        .fetch_count     (fetch_count)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model: where the stage is in its transaction, plus architectural state.
    logic        m_inrst = 1'b1;
    logic        m_trap  = 1'b0;
    logic        m_have  = 1'b0;
    logic [31:0] m_pc    = RPC;
    logic [31:0] m_count = '0;
    logic [31:0] m_instr = '0;

    // Stimulus for the next cycle.
    logic        s_rst    = 1'b1;
    logic        s_ready  = 1'b0;
    logic [31:0] s_rdata  = '0;
    logic        s_accept = 1'b0;
    logic        s_br     = 1'b0;
    logic        s_jump   = 1'b0;
    logic        s_jalr   = 1'b0;
    logic [31:0] s_imm    = '0;
    logic [31:0] s_rs1    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic br,
                                               input logic j, input logic jr,
                                               input logic [31:0] imm, input logic [31:0] rs1);
        logic [31:0] t;
        if (jr) begin
            t = rs1 + imm;
            t[0] = 1'b0;
        end else if (j || br) begin
            t = cur + imm;
        end else begin
            t = cur + 32'd4;
        end
        return t;
    endfunction

    task automatic check_model();
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("fetch_count", fetch_count, m_count);
        chk("misaligned_err", {31'b0, misaligned_err}, {31'b0, m_trap});
        if (m_inrst) begin
            chk("rst_req", {31'b0, imem_req}, 32'd0);
            chk("rst_valid", {31'b0, instr_valid}, 32'd0);
            chk("rst_instr", instruction, NOP_INSTR);
        end else if (m_trap) begin
            chk("trap_req", {31'b0, imem_req}, 32'd0);
            chk("trap_valid", {31'b0, instr_valid}, 32'd0);
        end else if (m_have) begin
            chk("hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("hold_req", {31'b0, imem_req}, 32'd0);
            chk("hold_instr", instruction, m_instr);
        end else begin
            chk("fetch_req", {31'b0, imem_req}, 32'd1);
            chk("fetch_valid", {31'b0, instr_valid}, 32'd0);
            chk("fetch_addr", imem_addr, m_pc);
        end
    endtask

    // Called at a falling edge: check, apply next stimulus, advance the model
    // to what the coming rising edge must produce, then wait one cycle.
    task automatic step();
        logic [31:0] nxt;
        check_model();
        imem_ready      = s_ready;
        imem_rdata      = s_rdata;
        instr_accept    = s_accept;
        branch_taken    = s_br;
        jump            = s_jump;
        jalr            = s_jalr;
        immediate_value = s_imm;
        rs1_value       = s_rs1;
        if (s_rst) begin
            if (!rst) begin
                rst = 1'b1;
                #1;
                chk("async_req", {31'b0, imem_req}, 32'd0);
                chk("async_valid", {31'b0, instr_valid}, 32'd0);
                chk("async_pc", pc, RPC);
            end
            m_inrst = 1'b1;
            m_trap  = 1'b0;
            m_have  = 1'b0;
            m_pc    = RPC;
            m_count = '0;
        end else begin
            rst = 1'b0;
            if (m_inrst) begin
                m_inrst = 1'b0;
            end else if (!m_trap) begin
                if (!m_have) begin
                    if (s_ready) begin
                        m_have  = 1'b1;
                        m_instr = s_rdata;
                    end
                end else if (s_accept) begin
                    nxt     = model_next(m_pc, s_br, s_jump, s_jalr, s_imm, s_rs1);
                    m_pc    = nxt;
                    m_count = m_count + 32'd1;
                    m_have  = 1'b0;
                    if (nxt[1:0] != 2'b00) m_trap = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic to_hold();
        for (int i = 0; i < 20 && !m_have; i++) begin
            s_ready  = 1'b1;
            s_accept = 1'b0;
            s_rdata  = $urandom;
            step();
        end
        chk("reach_hold", {31'b0, m_have}, 32'd1);
    endtask

    task automatic accept_ctl(input logic jr, input logic j, input logic br,
                              input logic [31:0] imm, input logic [31:0] rs1);
        to_hold();
        s_accept = 1'b1;
        s_jalr   = jr;
        s_jump   = j;
        s_br     = br;
        s_imm    = imm;
        s_rs1    = rs1;
        step();
        s_accept = 1'b0;
        s_jalr   = 1'b0;
        s_jump   = 1'b0;
        s_br     = 1'b0;
    endtask

    initial begin
        int ti;
        int unsigned sel;
        @(negedge clk);

        // Reset with memory already ready: response must be ignored.
        s_rst   = 1'b1;
        s_ready = 1'b1;
        s_rdata = 32'h0050_0093;
        step();
        step();
        s_rst = 1'b0;
        step();
        chk("boot_addr", imem_addr, 32'h0);
        chk("boot_req", {31'b0, imem_req}, 32'd1);
        step();
        chk("first_instr", instruction, 32'h0050_0093);
        s_accept = 1'b1;
        step();
        s_accept = 1'b0;
        chk("first_pc", pc, 32'h4);
        chk("first_count", fetch_count, 32'd1);

        // Backward branch from 0x100.
        accept_ctl(1'b0, 1'b1, 1'b0, 32'h100 - m_pc, '0);
        accept_ctl(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, '0);
        chk("branch_addr", imem_addr, 32'h0000_00F8);

        // JALR from 0x20 (jump also raised: jalr must win).
        accept_ctl(1'b0, 1'b1, 1'b0, 32'h20 - m_pc, '0);
        accept_ctl(1'b1, 1'b1, 1'b0, 32'h3, 32'h1001);
        chk("jalr_pc", pc, 32'h1004);
        chk("jalr_no_trap", {31'b0, misaligned_err}, 32'd0);

        // Stalled fetch, then reset in the middle of it.
        s_ready = 1'b0;
        repeat (3) step();
        chk("stall_addr", imem_addr, 32'h1004);
        s_rst   = 1'b1;
        s_ready = 1'b1;
        step();
        step();
        s_rst = 1'b0;
        step();

        // PC and fetch_count wrap.
        accept_ctl(1'b1, 1'b0, 1'b0, '0, 32'hFFFF_FFFC);
        to_hold();
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        m_count = 32'hFFFF_FFFF;
        accept_ctl(1'b0, 1'b0, 1'b0, '0, '0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_count", fetch_count, 32'h0);

        // Misaligned jump traps permanently.
        accept_ctl(1'b0, 1'b1, 1'b0, 32'h20 - m_pc, '0);
        accept_ctl(1'b0, 1'b1, 1'b0, 32'h6, '0);
        chk("trap_err", {31'b0, misaligned_err}, 32'd1);
        chk("trap_pc", pc, 32'h26);
        s_ready = 1'b1;
        repeat (6) step();
        chk("trap_stays", {31'b0, imem_req}, 32'd0);

        s_rst = 1'b1;
        step();
        s_rst = 1'b0;

        // Randomized traffic.
        repeat (3000) begin
            if (rst) s_rst = ($urandom % 2) == 0;
            else     s_rst = m_trap ? (($urandom % 6) == 0) : (($urandom % 150) == 0);
            s_ready  = ($urandom % 4) != 0;
            s_rdata  = $urandom;
            s_accept = ($urandom % 3) != 0;
            sel      = $urandom % 4;
            s_br     = (sel == 1) || (sel == 3 && ($urandom % 2) == 0);
            s_jump   = (sel == 2) || (sel == 3 && ($urandom % 2) == 0);
            s_jalr   = (sel == 3);
            ti       = int'($urandom_range(0, 64)) - 32;
            s_imm    = 32'(ti * 4);
            if (($urandom % 16) == 0) s_imm = s_imm + 32'($urandom % 4);
            s_rs1    = ($urandom & 32'hFFFF_FFFC) | 32'($urandom % 2);
            if (($urandom % 16) == 0) s_rs1 = s_rs1 | 32'h2;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
